// File: rtl/key_scan_arbiter.sv
// Shared debounce counter for KEY_NUM active-low push-buttons: pending presses
// are granted the counter in round-robin order and each stable press becomes one event.
module key_scan_arbiter #(
  parameter int          KEY_NUM = 4,
  parameter int          ID_W    = 2,
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [KEY_NUM-1:0] sync1_r;
  logic [KEY_NUM-1:0] key_s;
  logic [KEY_NUM-1:0] low_prev_r;
  logic [KEY_NUM-1:0] key_done_r;
  logic [KEY_NUM-1:0] req_s;
  logic [1:0]         state_r;
  logic [19:0]        cnt_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    grant_r;
  logic [ID_W-1:0]    evt_id_r;
  logic               evt_valid_r;
  logic               busy_r;
  logic [ID_W-1:0]    sel_s;
  logic               found_s;
  logic               hs_s;
  int                 idx_s;

  // Two-flop synchronizer; released (high) level out of reset so a held key reads as a new press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= '1;
      key_s   <= '1;
    end else begin
      sync1_r <= key_in;
      key_s   <= sync1_r;
    end
  end

  // Previous synchronized level: a key must read low on two consecutive samples before it requests.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      low_prev_r <= '0;
    end else begin
      low_prev_r <= ~key_s;
    end
  end

  assign hs_s  = evt_valid_r & evt_ready;
  assign req_s = ~key_s & low_prev_r & ~key_done_r;

  // Reported-key flags; a release clears the flag even if the handshake lands in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_done_r <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (key_s[i]) begin
          key_done_r[i] <= 1'b0;
        end else if (hs_s && (grant_r == ID_W'(i))) begin
          key_done_r[i] <= 1'b1;
        end else begin
          key_done_r[i] <= key_done_r[i];
        end
      end
    end
  end

  // Round-robin pick: first requester after rr_ptr, wrapping modulo KEY_NUM.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int off = 1; off <= KEY_NUM; off++) begin
      idx_s = (int'(rr_ptr_r) + off) % KEY_NUM;
      if (!found_s && req_s[idx_s]) begin
        sel_s   = ID_W'(idx_s);
        found_s = 1'b1;
      end else begin
        sel_s   = sel_s;
        found_s = found_s;
      end
    end
  end

  // Arbiter FSM: grant, count stable-low cycles, hold the event until accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 20'd0;
      rr_ptr_r    <= ID_W'(KEY_NUM - 1);
      grant_r     <= '0;
      evt_id_r    <= '0;
      evt_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r <= sel_s;
            cnt_r   <= 20'd0;
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (key_s[grant_r]) begin
            cnt_r    <= 20'd0;
            rr_ptr_r <= grant_r;
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end else if (cnt_r == (CNT_MAX - 20'd1)) begin
            evt_valid_r <= 1'b1;
            evt_id_r    <= grant_r;
            state_r     <= ST_REPORT;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        ST_REPORT: begin
          if (evt_ready) begin
            evt_valid_r <= 1'b0;
            rr_ptr_r    <= grant_r;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          evt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_id    = evt_id_r;
  assign grant_id  = grant_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter with CNT_MAX=15, KEY_NUM=4.
module tb_key_scan_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] grant_id;
  logic       busy;

  int tests;
  int fails;
  int cyc_n;
  int ev_id[$];
  int ev_stamp[$];
  int first_v;
  int nv;

  key_scan_arbiter #(.KEY_NUM(4), .ID_W(2), .CNT_MAX(20'd15)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Logs a handshake that the coming edge will perform, then advances one cycle.
  task automatic cyc();
    if (rst_n && evt_valid && evt_ready) begin
      ev_id.push_back(int'(evt_id));
      ev_stamp.push_back(cyc_n);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic mark();
    cyc_n = -1;
    ev_id.delete();
    ev_stamp.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_in    = 4'b1111;
    evt_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_id",    int'(evt_id), 0);
    rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  function automatic int q_at(input int which, input int i);
    if (which == 0) return (ev_id.size() > i) ? ev_id[i] : -99;
    else            return (ev_stamp.size() > i) ? ev_stamp[i] : -99;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    cyc_n = 0;

    // Single clean press on key 2
    do_reset();
    key_in[2] = 1'b0;
    mark();
    first_v = -1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (evt_valid) begin
        nv++;
        if (first_v < 0) first_v = i;
      end
    end
    chk("single_first_cycle", first_v, 18);
    chk("single_pulse_len", nv, 1);
    chk("single_ev_count", ev_id.size(), 1);
    chk("single_ev_id", q_at(0, 0), 2);
    key_in = 4'b1111;
    repeat (3) cyc();
    key_in[2] = 1'b0;
    mark();
    repeat (25) cyc();
    chk("repress_count", ev_id.size(), 1);
    chk("repress_id", q_at(0, 0), 2);
    chk("repress_cycle", q_at(1, 0), 18);

    // Bounce on key 1
    do_reset();
    key_in[1] = 1'b0;
    mark();
    for (int i = 0; i < 41; i++) begin
      cyc();
      if (i == 9)  key_in[1] = 1'b1;
      if (i == 10) key_in[1] = 1'b0;
      if (i == 11) chk("bounce_busy_counting", int'(busy), 1);
      if (i == 12) chk("bounce_abort_idle", int'(busy), 0);
    end
    chk("bounce_count", ev_id.size(), 1);
    chk("bounce_id", q_at(0, 0), 1);
    chk("bounce_cycle", q_at(1, 0), 29);

    // Round-robin contention on keys 0, 1, 3
    do_reset();
    key_in = 4'b0100;
    mark();
    repeat (80) cyc();
    chk("rr_count", ev_id.size(), 3);
    chk("rr_id0", q_at(0, 0), 0);
    chk("rr_id1", q_at(0, 1), 1);
    chk("rr_id2", q_at(0, 2), 3);
    chk("rr_cyc0", q_at(1, 0), 18);
    chk("rr_cyc1", q_at(1, 1), 35);
    chk("rr_cyc2", q_at(1, 2), 52);

    // Backpressure on key 3, key 0 pressed and key 3 released while waiting
    do_reset();
    evt_ready = 1'b0;
    key_in[3] = 1'b0;
    mark();
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (i == 17) chk("bp_valid_early", int'(evt_valid), 0);
      if (i == 18) chk("bp_valid_rise", int'(evt_valid), 1);
      if (i == 20) key_in[0] = 1'b0;
      if (i == 30) begin
        chk("bp_valid_hold", int'(evt_valid), 1);
        chk("bp_id_hold", int'(evt_id), 3);
        chk("bp_busy", int'(busy), 1);
      end
      if (i == 35) key_in[3] = 1'b1;
      if (i == 45) begin
        chk("bp_valid_after_release", int'(evt_valid), 1);
        chk("bp_id_after_release", int'(evt_id), 3);
        chk("bp_grant_stays", int'(grant_id), 3);
      end
    end
    chk("bp_no_handshake", ev_id.size(), 0);
    evt_ready = 1'b1;
    mark();
    repeat (25) cyc();
    chk("bp_count", ev_id.size(), 2);
    chk("bp_id0", q_at(0, 0), 3);
    chk("bp_id1", q_at(0, 1), 0);
    chk("bp_cyc1", q_at(1, 1), 16);

    // Reset while counting key 2, key held through reset
    do_reset();
    key_in[2] = 1'b0;
    mark();
    repeat (12) cyc();
    chk("rstmid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rstmid_valid", int'(evt_valid), 0);
      chk("rstmid_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    mark();
    repeat (25) cyc();
    chk("rstmid_count", ev_id.size(), 1);
    chk("rstmid_id", q_at(0, 0), 2);
    chk("rstmid_cycle", q_at(1, 0), 18);

    // Priority after abort: key 0 bounces while key 2 waits
    do_reset();
    key_in = 4'b1010;
    mark();
    for (int i = 0; i < 45; i++) begin
      cyc();
      if (i == 5) key_in[0] = 1'b1;
      if (i == 6) key_in[0] = 1'b0;
      if (i == 7) chk("prio_grant0", int'(grant_id), 0);
      if (i == 8) chk("prio_abort_idle", int'(busy), 0);
      if (i == 9) begin
        chk("prio_grant2", int'(grant_id), 2);
        chk("prio_busy2", int'(busy), 1);
      end
    end
    chk("prio_count", ev_id.size(), 2);
    chk("prio_id0", q_at(0, 0), 2);
    chk("prio_id1", q_at(0, 1), 0);
    chk("prio_cyc0", q_at(1, 0), 24);
    chk("prio_cyc1", q_at(1, 1), 41);

    // Asynchronous drop of evt_valid when reset hits during REPORT
    do_reset();
    evt_ready = 1'b0;
    key_in[1] = 1'b0;
    mark();
    repeat (20) cyc();
    chk("async_valid_before", int'(evt_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid_drop", int'(evt_valid), 0);
    chk("async_busy_drop", int'(busy), 0);
    cyc();
    key_in = 4'b1111;
    rst_n  = 1'b1;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
